dacx311_arbiter: RTL and testbench

Round-robin arbiter that shares one DACx311 serial driver among N independent setpoint requesters. Each requester posts a 12-bit code plus a 2-bit power-down mode into a private shadow register. On every driver frame boundary, signalled by `dac_ready`, the arbiter hands exactly one pending request to the driver's `data`/`pd` inputs. Between boundaries it holds those inputs stable, which satisfies the driver's rule that data changes only at ready.

---
 rtl/dacx311_arbiter.sv | 107 ++++++++++
 tb/tb_dacx311_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dacx311_arbiter.sv
// rtl/dacx311_arbiter.sv - round-robin arbiter sharing one DACx311 serial driver among N requesters.
// Holds dac_data_o/dac_pd_o stable between dac_ready_i boundaries and issues one shadow per frame.
module dacx311_arbiter #(
    parameter int          N          = 4,
    parameter logic [1:0]  RESET_PD   = 2'b00,
    parameter logic [11:0] RESET_DATA = 12'h000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    wr_i,
    input  logic [12*N-1:0] wr_data_i,
    input  logic [2*N-1:0]  wr_pd_i,
    output logic [N-1:0]    pending_o,
    output logic [N-1:0]    done_o,
    output logic [N-1:0]    overrun_o,
    output logic [2:0]      grant_id_o,
    input  logic            dac_ready_i,
    output logic [11:0]     dac_data_o,
    output logic [1:0]      dac_pd_o
);

    localparam int         IDW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [2:0] LAST_ID = 3'(N - 1);

    logic [N-1:0][13:0] shadow_q, shadow_d;
    logic [N-1:0]       pending_q, pending_d;
    logic [N-1:0]       done_q, done_d;
    logic [N-1:0]       overrun_q, overrun_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [11:0]        dac_data_q, dac_data_d;
    logic [1:0]         dac_pd_q, dac_pd_d;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic [N-1:0]       grant_vec;

    // Search starts one past the last grant and wraps; only the registered
    // pending vector is eligible, so same-cycle posts wait for the next frame.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(grant_id_q) + k) % N);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        pending_d  = pending_q;
        shadow_d   = shadow_q;
        overrun_d  = '0;
        grant_id_d = grant_id_q;
        dac_data_d = dac_data_q;
        dac_pd_d   = dac_pd_q;
        grant_vec  = '0;
        if (dac_ready_i && grant_found) begin
            grant_vec[grant_idx] = 1'b1;
            {dac_pd_d, dac_data_d} = shadow_q[grant_idx];
            grant_id_d = 3'(grant_idx);
        end
        done_d = grant_vec;
        // A post colliding with its own grant re-arms pending instead of overrunning.
        for (int i = 0; i < N; i++) begin
            if (grant_vec[i]) begin
                pending_d[i] = 1'b0;
            end
            if (wr_i[i]) begin
                shadow_d[i]  = {wr_pd_i[2*i +: 2], wr_data_i[12*i +: 12]};
                pending_d[i] = 1'b1;
                overrun_d[i] = pending_q[i] & ~grant_vec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q   <= '0;
            pending_q  <= '0;
            done_q     <= '0;
            overrun_q  <= '0;
            grant_id_q <= LAST_ID;
            dac_data_q <= RESET_DATA;
            dac_pd_q   <= RESET_PD;
        end else begin
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            grant_id_q <= grant_id_d;
            dac_data_q <= dac_data_d;
            dac_pd_q   <= dac_pd_d;
        end
    end

    assign pending_o  = pending_q;
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;
    assign grant_id_o = grant_id_q;
    assign dac_data_o = dac_data_q;
    assign dac_pd_o   = dac_pd_q;

endmodule

// File: tb/tb_dacx311_arbiter.sv
// tb/tb_dacx311_arbiter.sv - directed scoreboard bench for dacx311_arbiter.
module tb_dacx311_arbiter;

    localparam int N = 4;

    typedef struct {
        int          id;
        logic [11:0] data;
        logic [1:0]  pd;
    } grant_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    wr;
    logic [12*N-1:0] wr_data;
    logic [2*N-1:0]  wr_pd;
    logic [N-1:0]    pending;
    logic [N-1:0]    done;
    logic [N-1:0]    overrun;
    logic [2:0]      grant_id;
    logic            dac_ready;
    logic [11:0]     dac_data;
    logic [1:0]      dac_pd;

    int     tests = 0;
    int     fails = 0;
    grant_t exp_q[$];

    dacx311_arbiter #(.N(N), .RESET_PD(2'b00), .RESET_DATA(12'h000)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_i       (wr),
        .wr_data_i  (wr_data),
        .wr_pd_i    (wr_pd),
        .pending_o  (pending),
        .done_o     (done),
        .overrun_o  (overrun),
        .grant_id_o (grant_id),
        .dac_ready_i(dac_ready),
        .dac_data_o (dac_data),
        .dac_pd_o   (dac_pd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes last exactly one sampling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        wr        = '0;
        dac_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic post(input int id, input logic [11:0] d, input logic [1:0] p);
        wr[id]            = 1'b1;
        wr_data[12*id+:12] = d;
        wr_pd[2*id+:2]    = p;
    endtask

    task automatic expect_grant(input int id, input logic [11:0] d, input logic [1:0] p);
        grant_t g;
        g.id   = id;
        g.data = d;
        g.pd   = p;
        exp_q.push_back(g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Every done pulse must match the next scheduled grant.
    always @(negedge clk) begin
        if (done !== '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                grant_t g;
                g = exp_q.pop_front();
                check("done_vec", 32'(done), 32'(1 << g.id));
                check("grant_id", 32'(grant_id), 32'(g.id));
                check("dac_data", 32'(dac_data), 32'(g.data));
                check("dac_pd", 32'(dac_pd), 32'(g.pd));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        wr        = '0;
        wr_data   = '0;
        wr_pd     = '0;
        dac_ready = 1'b0;
        idle(2);
        reset = 1'b0;

        check("rst_pending", 32'(pending), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h3);
        check("rst_dac_data", 32'(dac_data), 32'h000);
        check("rst_dac_pd", 32'(dac_pd), 32'h0);

        // Single post, ready five cycles later
        post(2, 12'hABC, 2'd0);
        tick();
        check("single_pending", 32'(pending), 32'h4);
        idle(4);
        check("single_hold", 32'(dac_data), 32'h000);
        expect_grant(2, 12'hABC, 2'd0);
        dac_ready = 1'b1;
        tick();
        check("single_done", 32'(done), 32'h4);
        check("single_data", 32'(dac_data), 32'hABC);
        tick();
        check("single_cleared", 32'(pending), 32'h0);
        check("single_done_gone", 32'(done), 32'h0);

        // Round-robin fairness from a fresh reset
        do_reset();
        post(0, 12'h111, 2'd1);
        post(1, 12'h222, 2'd2);
        post(3, 12'h333, 2'd3);
        tick();
        check("rr_pending", 32'(pending), 32'hB);
        expect_grant(0, 12'h111, 2'd1);
        expect_grant(1, 12'h222, 2'd2);
        expect_grant(3, 12'h333, 2'd3);
        for (int r = 0; r < 3; r++) begin
            dac_ready = 1'b1;
            tick();
            idle(3);
        end
        check("rr_drained", 32'(pending), 32'h0);
        check("rr_hold", 32'(dac_data), 32'h333);
        post(0, 12'h444, 2'd0);
        post(3, 12'h555, 2'd1);
        tick();
        expect_grant(0, 12'h444, 2'd0);
        expect_grant(3, 12'h555, 2'd1);
        dac_ready = 1'b1;
        tick();
        idle(2);
        dac_ready = 1'b1;
        tick();
        idle(2);

        // Coalescing two posts before any ready
        post(1, 12'h100, 2'd0);
        tick();
        check("coal_no_ovr", 32'(overrun), 32'h0);
        post(1, 12'h200, 2'd1);
        tick();
        check("coal_ovr", 32'(overrun), 32'h2);
        tick();
        check("coal_ovr_once", 32'(overrun), 32'h0);
        expect_grant(1, 12'h200, 2'd1);
        dac_ready = 1'b1;
        tick();
        idle(2);
        dac_ready = 1'b1;
        tick();
        idle(2);

        // Post colliding with its own grant
        post(0, 12'h010, 2'd0);
        tick();
        expect_grant(0, 12'h010, 2'd0);
        post(0, 12'h020, 2'd2);
        dac_ready = 1'b1;
        tick();
        check("coll_data", 32'(dac_data), 32'h010);
        check("coll_pending", 32'(pending), 32'h1);
        check("coll_no_ovr", 32'(overrun), 32'h0);
        idle(2);
        expect_grant(0, 12'h020, 2'd2);
        dac_ready = 1'b1;
        tick();
        idle(2);

        // Idle ready pulses, then a post arriving with a ready
        for (int r = 0; r < 3; r++) begin
            dac_ready = 1'b1;
            tick();
            check("idle_data", 32'(dac_data), 32'h020);
            check("idle_grant_id", 32'(grant_id), 32'h0);
            idle(2);
        end
        post(3, 12'h7FF, 2'd2);
        dac_ready = 1'b1;
        tick();
        check("late_not_yet", 32'(dac_data), 32'h020);
        check("late_pending", 32'(pending), 32'h8);
        expect_grant(3, 12'h7FF, 2'd2);
        dac_ready = 1'b1;
        tick();
        idle(2);

        // Reset with requests queued
        post(0, 12'hA00, 2'd1);
        post(1, 12'hA01, 2'd1);
        post(2, 12'hA02, 2'd1);
        tick();
        check("rq_pending", 32'(pending), 32'h7);
        do_reset();
        check("rq_pending_clr", 32'(pending), 32'h0);
        check("rq_dac_data", 32'(dac_data), 32'h000);
        check("rq_grant_id", 32'(grant_id), 32'h3);
        dac_ready = 1'b1;
        tick();
        idle(2);
        post(0, 12'hB00, 2'd0);
        post(2, 12'hB02, 2'd3);
        tick();
        expect_grant(0, 12'hB00, 2'd0);
        expect_grant(2, 12'hB02, 2'd3);
        dac_ready = 1'b1;
        tick();
        idle(2);
        dac_ready = 1'b1;
        tick();
        idle(3);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
